// File: rtl/int_seq_pkg.sv
// int_seq_pkg: shared state encoding and default vector for the interrupt stack sequencer.
package int_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH_PC, PUSH_CCR, FETCH_VEC, JUMP, RDRAIN, POP_CCR, POP_PC
  } state_t;
  localparam logic [7:0] DEFAULT_VECTOR = 8'h00;
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: multi-flop synchronizer followed by a rising-edge detector.
module int_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  localparam int N = (STAGES < 2) ? 2 : STAGES;
  logic [N-1:0] sync;
  logic last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      last <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], din};
      last <= sync[N-1];
    end
  end
  assign rise = sync[N-1] & ~last;
endmodule

// File: rtl/int_stack_sequencer.sv
// int_stack_sequencer: interrupt entry / RTI sequencer owning the RAM and SP ports while busy.
// Define INT_SAVE_FLAGS_EN to also push/pop the 4-bit CCR around the return PC.
module int_stack_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [7:0] VECTOR_ADDR = DEFAULT_VECTOR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Interrupt,
  input  logic       RTI_Req,
  input  logic       Pipe_Empty,
  input  logic [7:0] PC_Current,
  input  logic [7:0] SP_In,
  input  logic [7:0] Mem_RData,
`ifdef INT_SAVE_FLAGS_EN
  input  logic [3:0] CCR_In,
  output logic [3:0] CCR_Out,
  output logic       CCR_WE,
`endif
  output logic       Busy,
  output logic       Stall_Fetch,
  output logic       Flush,
  output logic [7:0] Mem_Addr,
  output logic [7:0] Mem_WData,
  output logic       Mem_WE,
  output logic [7:0] SP_Out,
  output logic       SP_WE,
  output logic       PC_Load,
  output logic [7:0] PC_Load_Val,
  output logic       Int_Ack,
  output logic       In_Handler,
  output logic       Stack_Err
);
  state_t state;
  logic pending, rise, push, pop;
  logic [7:0] vec_q, ccr_word;

`ifdef INT_SAVE_FLAGS_EN
  localparam bit SAVE_CCR = 1'b1;
  assign ccr_word = {4'b0, CCR_In};
  assign CCR_WE   = state == POP_CCR;
  assign CCR_Out  = CCR_WE ? Mem_RData[3:0] : 4'h0;
`else
  localparam bit SAVE_CCR = 1'b0;
  assign ccr_word = 8'h00;
`endif

  int_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .din (Interrupt),
    .rise(rise)
  );

  // Clearing pending in JUMP wins over an edge arriving in that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      vec_q      <= 8'h00;
      In_Handler <= 1'b0;
      Stack_Err  <= 1'b0;
    end else begin
      if (rise && !In_Handler) pending <= 1'b1;
      case (state)
        IDLE:      state <= (RTI_Req && In_Handler) ? RDRAIN : pending ? DRAIN : IDLE;
        DRAIN:     if (Pipe_Empty) state <= PUSH_PC;
        PUSH_PC: begin
          state <= SAVE_CCR ? PUSH_CCR : FETCH_VEC;
          if (SP_In == 8'h00) Stack_Err <= 1'b1;
        end
        PUSH_CCR: begin
          state <= FETCH_VEC;
          if (SP_In == 8'h00) Stack_Err <= 1'b1;
        end
        FETCH_VEC: begin
          vec_q <= Mem_RData;
          state <= JUMP;
        end
        JUMP: begin
          pending    <= 1'b0;
          In_Handler <= 1'b1;
          state      <= IDLE;
        end
        RDRAIN:    if (Pipe_Empty) state <= SAVE_CCR ? POP_CCR : POP_PC;
        POP_CCR: begin
          state <= POP_PC;
          if (SP_In == 8'hFF) Stack_Err <= 1'b1;
        end
        POP_PC: begin
          In_Handler <= 1'b0;
          state      <= IDLE;
          if (SP_In == 8'hFF) Stack_Err <= 1'b1;
        end
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    push        = state == PUSH_PC || state == PUSH_CCR;
    pop         = state == POP_CCR || state == POP_PC;
    Busy        = state != IDLE;
    Stall_Fetch = state != IDLE;
    Mem_Addr    = push ? SP_In : pop ? SP_In + 8'd1 : (state == FETCH_VEC) ? VECTOR_ADDR : 8'h00;
    Mem_WData   = (state == PUSH_PC) ? PC_Current : (state == PUSH_CCR) ? ccr_word : 8'h00;
    Mem_WE      = push;
    SP_WE       = push | pop;
    SP_Out      = push ? SP_In - 8'd1 : pop ? SP_In + 8'd1 : 8'h00;
    PC_Load     = state == JUMP || state == POP_PC;
    PC_Load_Val = (state == JUMP) ? vec_q : (state == POP_PC) ? Mem_RData : 8'h00;
    Flush       = PC_Load;
    Int_Ack     = state == JUMP;
  end
endmodule

// File: tb/tb_int_stack_sequencer.sv
// tb_int_stack_sequencer: randomized bench with a RAM/R3 environment and a stack-level reference model.
// Works with or without INT_SAVE_FLAGS_EN.
module tb_int_stack_sequencer;
  import int_seq_pkg::*;
  localparam logic [7:0] VEC = DEFAULT_VECTOR;
`ifdef INT_SAVE_FLAGS_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic Interrupt = 1'b0, RTI_Req = 1'b0, Pipe_Empty = 1'b1;
  logic [7:0] PC_Current = 8'h00, SP_In, Mem_RData;
  logic Busy, Stall_Fetch, Flush, Mem_WE, SP_WE, PC_Load, Int_Ack, In_Handler, Stack_Err;
  logic [7:0] Mem_Addr, Mem_WData, SP_Out, PC_Load_Val;
`ifdef INT_SAVE_FLAGS_EN
  logic [3:0] CCR_In = 4'h0, CCR_Out, ccr_reg = 4'h0;
  logic CCR_WE;
`endif

  logic [7:0] mem [256];
  logic [7:0] sp = 8'hFF, pc_loaded = 8'h00;
  int we_cnt = 0, spwe_cnt = 0, pcl_cnt = 0, ack_cnt = 0, flush_cnt = 0;
  int checks = 0, failures = 0;
  bit m_err = 1'b0;
  logic [7:0] saved_pc;
  logic [3:0] saved_ccr = 4'h0;

  int_stack_sequencer dut (
    .clk(clk), .rst(rst), .Interrupt(Interrupt), .RTI_Req(RTI_Req), .Pipe_Empty(Pipe_Empty),
    .PC_Current(PC_Current), .SP_In(SP_In), .Mem_RData(Mem_RData),
`ifdef INT_SAVE_FLAGS_EN
    .CCR_In(CCR_In), .CCR_Out(CCR_Out), .CCR_WE(CCR_WE),
`endif
    .Busy(Busy), .Stall_Fetch(Stall_Fetch), .Flush(Flush), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_WE(Mem_WE), .SP_Out(SP_Out), .SP_WE(SP_WE),
    .PC_Load(PC_Load), .PC_Load_Val(PC_Load_Val), .Int_Ack(Int_Ack),
    .In_Handler(In_Handler), .Stack_Err(Stack_Err)
  );

  always #5 clk = ~clk;
  assign SP_In     = sp;
  assign Mem_RData = mem[Mem_Addr];

  // Processor side: RAM, R3 and PC redirect bookkeeping.
  always @(posedge clk) begin
    if (Mem_WE) mem[Mem_Addr] <= Mem_WData;
    if (SP_WE) sp <= SP_Out;
    if (PC_Load) pc_loaded <= PC_Load_Val;
`ifdef INT_SAVE_FLAGS_EN
    if (CCR_WE) ccr_reg <= CCR_Out;
`endif
    we_cnt    <= we_cnt + int'(Mem_WE);
    spwe_cnt  <= spwe_cnt + int'(SP_WE);
    pcl_cnt   <= pcl_cnt + int'(PC_Load);
    ack_cnt   <= ack_cnt + int'(Int_Ack);
    flush_cnt <= flush_cnt + int'(Flush);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (!Busy && t < 40) begin tick(); t++; end
    chk({tag, "_busy"}, Busy, 1);
  endtask

  task automatic wait_pcl(input int base, input string tag);
    int t = 0;
    while (pcl_cnt == base && t < 60) begin tick(); t++; end
    chk({tag, "_pcload_seen"}, pcl_cnt != base, 1);
  endtask

  task automatic entry(input logic [7:0] s, input logic [7:0] pc, input logic [7:0] v,
                       input int pe_delay, input bit lat_chk);
    logic [7:0] e_sp, e_vec;
    int b_pcl, b_ack, b_fl, n;
    sp = s; mem[VEC] = v; PC_Current = pc;
    e_vec = (s == VEC) ? pc : v;
    e_sp = s - 8'd1;
    m_err |= (s == 8'h00);
`ifdef INT_SAVE_FLAGS_EN
    CCR_In = 4'($urandom);
    saved_ccr = CCR_In;
    if (e_sp == VEC) e_vec = {4'b0, CCR_In};
    m_err |= (e_sp == 8'h00);
    e_sp = e_sp - 8'd1;
`endif
    b_pcl = pcl_cnt; b_ack = ack_cnt; b_fl = flush_cnt;
    Pipe_Empty = (pe_delay == 0);
    Interrupt = 1'b1;
    wait_busy("entry");
    if (lat_chk) begin
      n = 1;
      while (!PC_Load && n < 20) begin tick(); n++; end
      chk("entry_latency", n, LAT);
    end
    for (int i = 0; i < pe_delay; i++) begin
      chk("drain_stall_no_we", {Stall_Fetch, Mem_WE, SP_WE}, 3'b100);
      tick();
    end
    Pipe_Empty = 1'b1;
    wait_pcl(b_pcl, "entry");
    tick(2);
    Interrupt = 1'b0;
    chk("entry_ret_pc", mem[s], pc);
`ifdef INT_SAVE_FLAGS_EN
    chk("entry_ccr", mem[s - 8'd1], {4'b0, saved_ccr});
`endif
    chk("entry_sp", sp, e_sp);
    chk("entry_vector", pc_loaded, e_vec);
    chk("entry_ack_once", ack_cnt - b_ack, 1);
    chk("entry_flush_once", flush_cnt - b_fl, 1);
    chk("entry_in_handler", In_Handler, 1);
    chk("entry_stack_err", Stack_Err, m_err);
    saved_pc = pc;
    tick(4);
  endtask

  task automatic rti(input int pe_delay, input bit poke);
    logic [7:0] s, e_sp;
    int b_pcl, b_ack, b_fl;
    s = sp;
    m_err |= (s == 8'hFF);
    e_sp = s + 8'd1;
`ifdef INT_SAVE_FLAGS_EN
    m_err |= (e_sp == 8'hFF);
    e_sp = e_sp + 8'd1;
`endif
    b_pcl = pcl_cnt; b_ack = ack_cnt; b_fl = flush_cnt;
    Pipe_Empty = (pe_delay == 0);
    RTI_Req = 1'b1;
    tick();
    RTI_Req = 1'b0;
    if (poke) Interrupt = 1'b1;
    tick(pe_delay);
    Pipe_Empty = 1'b1;
    wait_pcl(b_pcl, "rti");
    tick();
    chk("rti_pc", pc_loaded, saved_pc);
    chk("rti_sp", sp, e_sp);
    chk("rti_in_handler", In_Handler, 0);
    chk("rti_flush_once", flush_cnt - b_fl, 1);
    chk("rti_no_ack", ack_cnt - b_ack, 0);
    chk("rti_stack_err", Stack_Err, m_err);
`ifdef INT_SAVE_FLAGS_EN
    chk("rti_ccr", ccr_reg, saved_ccr);
`endif
    if (poke) begin
      b_pcl = pcl_cnt;
      tick(10);
      chk("rdrain_edge_dropped", {Busy, 8'(pcl_cnt - b_pcl)}, 0);
      Interrupt = 1'b0;
    end
    tick(4);
  endtask

  initial begin
    int b_we, b_pcl, b_spwe, pe;
    bit poke;
    logic [7:0] s;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick(3);
    chk("reset_outputs", {Busy, Stall_Fetch, Flush, Mem_WE, SP_WE, PC_Load, Int_Ack, In_Handler,
                          Stack_Err, Mem_Addr, Mem_WData, SP_Out, PC_Load_Val}, 0);
    rst = 1'b1;
    tick(4);

    entry(8'hFF, 8'h06, 8'h40, 0, 1'b1);
    rti(0, 1'b0);

    entry(8'hA0, 8'h12, 8'h55, 0, 1'b0);
    b_we = we_cnt; s = sp;
    Interrupt = 1'b1; tick(3); Interrupt = 1'b0; tick(10);
    chk("mask_no_we", we_cnt - b_we, 0);
    chk("mask_sp_kept", sp, s);
    chk("mask_idle", Busy, 0);
    rti(2, 1'b0);
    entry(8'h80, 8'h33, 8'h77, 5, 1'b0);
    rti(1, 1'b0);

    entry(8'h00, 8'h21, 8'h99, 0, 1'b0);
    rti(0, 1'b0);
    chk("stack_err_sticky", Stack_Err, 1);

    b_pcl = pcl_cnt;
    RTI_Req = 1'b1; tick(); RTI_Req = 1'b0; tick(6);
    chk("rti_ignored", {Busy, 8'(pcl_cnt - b_pcl)}, 0);

    Pipe_Empty = 1'b0;
    Interrupt = 1'b1;
    wait_busy("rst_mid");
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {Busy, Stall_Fetch, Flush, Mem_WE, SP_WE, PC_Load, Int_Ack,
                                   In_Handler, Stack_Err, Mem_Addr, Mem_WData, SP_Out}, 0);
    Interrupt = 1'b0;
    Pipe_Empty = 1'b1;
    tick(3);
    rst = 1'b1;
    m_err = 1'b0;
    b_pcl = pcl_cnt; b_spwe = spwe_cnt;
    tick(12);
    chk("post_reset_no_spwe", spwe_cnt - b_spwe, 0);
    chk("post_reset_no_pcload", pcl_cnt - b_pcl, 0);

    for (int k = 0; k < 20; k++) begin
      pe = $urandom_range(0, 4);
      entry(8'($urandom), 8'($urandom), 8'($urandom), pe, pe == 0);
      poke = ($urandom_range(0, 2) == 0);
      rti(poke ? $urandom_range(5, 7) : $urandom_range(0, 3), poke);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
